// File: rtl/gl_triangle_fifo_if.sv
// Vertex-in / triangle-out bundle between the transform stage, the triangle FIFO and the rasterizer.
// The master side is the environment; the slave side is the triangle FIFO itself.
interface gl_triangle_fifo_if #(
    parameter int unsigned VERTEX_TYPE_SIZE = 96,
    parameter int unsigned ADDR_W           = 2
);
    logic                        vert_valid;
    logic [VERTEX_TYPE_SIZE-1:0] vert_data;
    logic                        vert_ready;
    logic                        prim_restart;
    logic                        fifo_ready;
    logic [VERTEX_TYPE_SIZE-1:0] fifo_out1;
    logic [VERTEX_TYPE_SIZE-1:0] fifo_out2;
    logic [VERTEX_TYPE_SIZE-1:0] fifo_out3;
    logic                        raster_ready;
    logic [ADDR_W:0]             tri_count;
    logic                        busy;

    modport master (
        output vert_valid, vert_data, prim_restart, raster_ready,
        input  vert_ready, fifo_ready, fifo_out1, fifo_out2, fifo_out3, tri_count, busy
    );

    modport slave (
        input  vert_valid, vert_data, prim_restart, raster_ready,
        output vert_ready, fifo_ready, fifo_out1, fifo_out2, fifo_out3, tri_count, busy
    );
endinterface

// File: rtl/gl_triangle_fifo.sv
// Assembles single vertices into triangles, buffers DEPTH of them and hands them to the
// rasterizer one at a time with a one-cycle fifo_ready strobe and a raster_ready retire.
module gl_triangle_fifo #(
    parameter int unsigned VERTEX_TYPE_SIZE = 96,
    parameter int unsigned DEPTH            = 4,
    parameter int unsigned ADDR_W           = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    gl_triangle_fifo_if.slave bus
);
    localparam int unsigned VW = VERTEX_TYPE_SIZE;
    localparam int unsigned TW = 3 * VERTEX_TYPE_SIZE;
    localparam int unsigned CW = ADDR_W + 1;

    typedef enum logic {ST_IDLE, ST_FLIGHT} state_e;

    state_e              state_q,      state_d;
    logic [1:0]          vidx_q,       vidx_d;
    logic [VW-1:0]       asm_v1_q,     asm_v1_d;
    logic [VW-1:0]       asm_v2_q,     asm_v2_d;
    logic [TW-1:0]       mem_q [DEPTH];
    logic [TW-1:0]       mem_d [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q,     wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q,     rd_ptr_d;
    logic [CW-1:0]       tri_count_q,  tri_count_d;
    logic [VW-1:0]       fifo_out1_q,  fifo_out1_d;
    logic [VW-1:0]       fifo_out2_q,  fifo_out2_d;
    logic [VW-1:0]       fifo_out3_q,  fifo_out3_d;
    logic                fifo_ready_q, fifo_ready_d;
    logic                busy_q,       busy_d;

    logic vert_ready_c;
    logic accept_c;
    logic push_c;
    logic retire_c;

    // Only the completing vertex can stall; the in-flight slot still counts toward full.
    assign vert_ready_c = !((tri_count_q == CW'(DEPTH)) && (vidx_q == 2'd2));
    assign accept_c     = bus.vert_valid && vert_ready_c;
    assign push_c       = accept_c && !bus.prim_restart && (vidx_q == 2'd2);
    assign retire_c     = (state_q == ST_FLIGHT) && bus.raster_ready;

    // Vertex assembly and slot write; restart wins over a same-cycle vertex.
    always_comb begin
        vidx_d   = vidx_q;
        asm_v1_d = asm_v1_q;
        asm_v2_d = asm_v2_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        if (bus.prim_restart) begin
            vidx_d = 2'd0;
        end else if (accept_c) begin
            case (vidx_q)
                2'd0: begin
                    asm_v1_d = bus.vert_data;
                    vidx_d   = 2'd1;
                end
                2'd1: begin
                    asm_v2_d = bus.vert_data;
                    vidx_d   = 2'd2;
                end
                default: begin
                    mem_d[wr_ptr_q] = {asm_v1_q, asm_v2_q, bus.vert_data};
                    wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
                    vidx_d          = 2'd0;
                end
            endcase
        end
    end

    // Occupancy: a push and a retire in the same cycle cancel out.
    always_comb begin
        tri_count_d = tri_count_q;
        case ({push_c, retire_c})
            2'b10:   tri_count_d = tri_count_q + CW'(1);
            2'b01:   tri_count_d = tri_count_q - CW'(1);
            default: tri_count_d = tri_count_q;
        endcase
    end

    // Output FSM: strobe the head triangle once, hold it until the rasterizer retires it.
    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_out1_d  = fifo_out1_q;
        fifo_out2_d  = fifo_out2_q;
        fifo_out3_d  = fifo_out3_q;
        fifo_ready_d = 1'b0;
        busy_d       = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (tri_count_q != '0) begin
                    {fifo_out1_d, fifo_out2_d, fifo_out3_d} = mem_q[rd_ptr_q];
                    fifo_ready_d = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = ST_FLIGHT;
                end
            end
            default: begin
                if (bus.raster_ready) begin
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vidx_q       <= 2'd0;
            asm_v1_q     <= '0;
            asm_v2_q     <= '0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tri_count_q  <= '0;
            fifo_out1_q  <= '0;
            fifo_out2_q  <= '0;
            fifo_out3_q  <= '0;
            fifo_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vidx_q       <= vidx_d;
            asm_v1_q     <= asm_v1_d;
            asm_v2_q     <= asm_v2_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tri_count_q  <= tri_count_d;
            fifo_out1_q  <= fifo_out1_d;
            fifo_out2_q  <= fifo_out2_d;
            fifo_out3_q  <= fifo_out3_d;
            fifo_ready_q <= fifo_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.vert_ready = vert_ready_c;
    assign bus.fifo_ready = fifo_ready_q;
    assign bus.fifo_out1  = fifo_out1_q;
    assign bus.fifo_out2  = fifo_out2_q;
    assign bus.fifo_out3  = fifo_out3_q;
    assign bus.tri_count  = tri_count_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_gl_triangle_fifo.sv
// Directed bench for gl_triangle_fifo: assembly, full stall, restart, push/retire overlap,
// asynchronous reset and back-to-back retirement.
module tb_gl_triangle_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [287:0] got_q[$];

    always #5 clk = ~clk;

    gl_triangle_fifo_if #(.VERTEX_TYPE_SIZE(96), .ADDR_W(2)) bus ();

    gl_triangle_fifo #(.VERTEX_TYPE_SIZE(96), .DEPTH(4), .ADDR_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Record every presented triangle; fifo_ready is high for exactly one full cycle.
    always @(negedge clk)
        if (rst_n && bus.fifo_ready) got_q.push_back({bus.fifo_out1, bus.fifo_out2, bus.fifo_out3});

    function automatic logic [95:0] mkv(input int t, input int k);
        return {32'h4000_0000 | 32'(t * 4 + k), 32'hC0DE_0000 | 32'(k), 32'(t)};
    endfunction

    function automatic logic [287:0] mkt(input int t);
        return {mkv(t, 0), mkv(t, 1), mkv(t, 2)};
    endfunction

    task automatic do_reset();
        bus.vert_valid = 1'b0; bus.vert_data = '0; bus.prim_restart = 1'b0; bus.raster_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got_q.delete();
    endtask

    // Offer one vertex from a negedge and return at the negedge after it was accepted.
    task automatic drive_vtx(input logic [95:0] v);
        bit   done = 1'b0;
        logic rdy;
        bus.vert_valid = 1'b1;
        bus.vert_data  = v;
        for (int c = 0; c < 50 && !done; c++) begin
            rdy = bus.vert_ready;
            @(negedge clk);
            if (rdy) done = 1'b1;
        end
        bus.vert_valid = 1'b0;
        checks++;
        if (!done) begin errors++; $display("FAIL drive_vtx: vertex %h not accepted within 50 cycles", v); end
    endtask

    task automatic retire_all();
        bit done = 1'b0;
        bus.raster_ready = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.tri_count == 3'd0 && !bus.busy) done = 1'b1;
        end
        bus.raster_ready = 1'b0;
        checks++;
        if (!done) begin errors++; $display("FAIL retire_all: tri_count=%0d busy=%0b after 100 cycles, required 0/0", bus.tri_count, bus.busy); end
    endtask

    task automatic test_reset();
        bus.vert_valid = 1'b0; bus.vert_data = '0; bus.prim_restart = 1'b0; bus.raster_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.tri_count !== 3'd0) begin errors++; $display("FAIL reset_tri_count: got %0d, required 0", bus.tri_count); end
        checks++; if (bus.fifo_ready !== 1'b0) begin errors++; $display("FAIL reset_fifo_ready: got %b, required 0", bus.fifo_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
        checks++; if (bus.vert_ready !== 1'b1) begin errors++; $display("FAIL reset_vert_ready: got %b, required 1", bus.vert_ready); end
        checks++; if (bus.fifo_out1 !== 96'd0) begin errors++; $display("FAIL reset_fifo_out1: got %h, required 0", bus.fifo_out1); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_reset();
        drive_vtx({32'h3F80_0000, 64'd0});
        drive_vtx({32'h4000_0000, 64'd0});
        drive_vtx({32'h4040_0000, 64'd0});
        checks++; if (bus.tri_count !== 3'd1) begin errors++; $display("FAIL basic_count: got %0d, required 1", bus.tri_count); end
        checks++; if (bus.fifo_ready !== 1'b0) begin errors++; $display("FAIL basic_latency: fifo_ready=%b at completing edge, required 0", bus.fifo_ready); end
        @(negedge clk);
        checks++; if (bus.fifo_ready !== 1'b1) begin errors++; $display("FAIL basic_strobe: got %b, required 1", bus.fifo_ready); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b, required 1", bus.busy); end
        checks++; if (bus.fifo_out1[95:64] !== 32'h3F80_0000) begin errors++; $display("FAIL basic_out1_x: got %h, required 3f800000", bus.fifo_out1[95:64]); end
        checks++; if (bus.fifo_out2[95:64] !== 32'h4000_0000) begin errors++; $display("FAIL basic_out2_x: got %h, required 40000000", bus.fifo_out2[95:64]); end
        checks++; if (bus.fifo_out3[95:64] !== 32'h4040_0000) begin errors++; $display("FAIL basic_out3_x: got %h, required 40400000", bus.fifo_out3[95:64]); end
        @(negedge clk);
        checks++; if (bus.fifo_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL basic_hold: fifo_ready=%b busy=%b, required 0/1", bus.fifo_ready, bus.busy); end
        checks++; if (bus.fifo_out3[95:64] !== 32'h4040_0000) begin errors++; $display("FAIL basic_out_stable: got %h, required 40400000", bus.fifo_out3[95:64]); end
        bus.raster_ready = 1'b1;
        @(negedge clk);
        bus.raster_ready = 1'b0;
        checks++; if (bus.tri_count !== 3'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_retire: tri_count=%0d busy=%b, required 0/0", bus.tri_count, bus.busy); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL basic_pulses: got %0d strobes, required 1", got_q.size()); end
    endtask

    task automatic test_full();
        do_reset();
        for (int t = 0; t < 4; t++)
            for (int k = 0; k < 3; k++) drive_vtx(mkv(t, k));
        drive_vtx(mkv(4, 0));
        drive_vtx(mkv(4, 1));
        bus.vert_valid = 1'b1;
        bus.vert_data  = mkv(4, 2);
        checks++; if (bus.vert_ready !== 1'b0) begin errors++; $display("FAIL full_stall: vert_ready=%b, required 0", bus.vert_ready); end
        checks++; if (bus.tri_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d, required 4", bus.tri_count); end
        repeat (3) @(negedge clk);
        checks++; if (bus.vert_ready !== 1'b0 || bus.tri_count !== 3'd4) begin errors++; $display("FAIL full_hold: vert_ready=%b tri_count=%0d, required 0/4", bus.vert_ready, bus.tri_count); end
        bus.raster_ready = 1'b1;
        @(negedge clk);
        bus.raster_ready = 1'b0;
        checks++; if (bus.tri_count !== 3'd3 || bus.vert_ready !== 1'b1) begin errors++; $display("FAIL full_release: tri_count=%0d vert_ready=%b, required 3/1", bus.tri_count, bus.vert_ready); end
        @(negedge clk);
        bus.vert_valid = 1'b0;
        checks++; if (bus.tri_count !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d, required 4", bus.tri_count); end
        retire_all();
        #1;
        checks++;
        if (got_q.size() != 5) begin
            errors++; $display("FAIL full_order_count: got %0d triangles, required 5", got_q.size());
        end else begin
            for (int i = 0; i < 5; i++)
                if (got_q[i] !== mkt(i)) begin errors++; $display("FAIL full_order[%0d]: got %h, required %h", i, got_q[i], mkt(i)); end
        end
    endtask

    task automatic test_restart();
        do_reset();
        drive_vtx(mkv(9, 0));
        drive_vtx(mkv(9, 1));
        bus.prim_restart = 1'b1;
        bus.vert_valid   = 1'b1;
        bus.vert_data    = mkv(9, 2);
        @(negedge clk);
        bus.prim_restart = 1'b0;
        bus.vert_valid   = 1'b0;
        checks++; if (bus.tri_count !== 3'd0) begin errors++; $display("FAIL restart_discard: tri_count=%0d, required 0", bus.tri_count); end
        drive_vtx(mkv(5, 0));
        drive_vtx(mkv(5, 1));
        drive_vtx(mkv(5, 2));
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL restart_count: got %0d triangles, required 1", got_q.size()); end
        else if (got_q[0] !== mkt(5)) begin errors++; $display("FAIL restart_tri: got %h, required %h", got_q[0], mkt(5)); end
        retire_all();
    endtask

    task automatic test_simul();
        do_reset();
        for (int t = 0; t < 2; t++)
            for (int k = 0; k < 3; k++) drive_vtx(mkv(t, k));
        drive_vtx(mkv(2, 0));
        drive_vtx(mkv(2, 1));
        checks++; if (bus.tri_count !== 3'd2 || bus.busy !== 1'b1) begin errors++; $display("FAIL simul_pre: tri_count=%0d busy=%b, required 2/1", bus.tri_count, bus.busy); end
        bus.vert_valid   = 1'b1;
        bus.vert_data    = mkv(2, 2);
        bus.raster_ready = 1'b1;
        @(negedge clk);
        bus.vert_valid   = 1'b0;
        bus.raster_ready = 1'b0;
        checks++; if (bus.tri_count !== 3'd2 || bus.busy !== 1'b0) begin errors++; $display("FAIL simul_count: tri_count=%0d busy=%b, required 2/0", bus.tri_count, bus.busy); end
        @(negedge clk);
        checks++; if (bus.fifo_ready !== 1'b1) begin errors++; $display("FAIL simul_strobe: got %b, required 1", bus.fifo_ready); end
        checks++; if ({bus.fifo_out1, bus.fifo_out2, bus.fifo_out3} !== mkt(1)) begin errors++; $display("FAIL simul_next_tri: got %h, required %h", {bus.fifo_out1, bus.fifo_out2, bus.fifo_out3}, mkt(1)); end
        retire_all();
        #1;
        checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL simul_total: got %0d triangles, required 3", got_q.size()); end
        else if (got_q[2] !== mkt(2)) begin errors++; $display("FAIL simul_last: got %h, required %h", got_q[2], mkt(2)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int t = 0; t < 3; t++)
            for (int k = 0; k < 3; k++) drive_vtx(mkv(t, k));
        checks++; if (bus.tri_count !== 3'd3 || bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_pre: tri_count=%0d busy=%b, required 3/1", bus.tri_count, bus.busy); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.tri_count !== 3'd0) begin errors++; $display("FAIL midrst_count: got %0d, required 0", bus.tri_count); end
        checks++; if (bus.busy !== 1'b0 || bus.fifo_ready !== 1'b0) begin errors++; $display("FAIL midrst_flags: busy=%b fifo_ready=%b, required 0/0", bus.busy, bus.fifo_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit done = 1'b0;
        int pulses;
        do_reset();
        for (int t = 10; t < 14; t++)
            for (int k = 0; k < 3; k++) drive_vtx(mkv(t, k));
        checks++; if (bus.tri_count !== 3'd4) begin errors++; $display("FAIL b2b_queued: got %0d, required 4", bus.tri_count); end
        bus.raster_ready = 1'b1;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (bus.tri_count == 3'd0) done = 1'b1;
        end
        repeat (4) @(negedge clk);
        bus.raster_ready = 1'b0;
        #1;
        pulses = got_q.size();
        checks++; if (!done) begin errors++; $display("FAIL b2b_drain: tri_count=%0d, required 0", bus.tri_count); end
        checks++;
        if (pulses != 4) begin
            errors++; $display("FAIL b2b_pulses: got %0d strobes, required 4", pulses);
        end else begin
            for (int i = 0; i < 4; i++)
                if (got_q[i] !== mkt(10 + i)) begin errors++; $display("FAIL b2b_tri[%0d]: got %h, required %h", i, got_q[i], mkt(10 + i)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_restart();
        test_simul();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
